// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and word width.
package data_mem_access_pkg;

  localparam int WORD_BITS = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane logic: merges store data into a word (RMW) and extracts/extends
// the addressed lane of a loaded word (little-endian).
module byte_lane_merge
  import data_mem_access_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           off,
  input  logic                 sgn,
  input  logic [WORD_BITS-1:0] old_word,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_BITS-1:0] ld_word,
  output logic [WORD_BITS-1:0] st_word,
  output logic [WORD_BITS-1:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_word = old_word;
    ld_data = '0;
    byte_v  = '0;
    half_v  = '0;
    case (size)
      SZ_BYTE: begin
        st_word[{off, 3'b000} +: 8] = wdata[7:0];
        byte_v  = ld_word[{off, 3'b000} +: 8];
        ld_data = {{(WORD_BITS-8){sgn & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
        half_v  = ld_word[{off[1], 4'b0000} +: 16];
        ld_data = {{(WORD_BITS-16){sgn & half_v[15]}}, half_v};
      end
      // size 11 is normalised to word before reaching here; word ignores sgn
      default: begin
        st_word = wdata;
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Load/store unit between the memory stage and a single-cycle word-addressed data memory.
// Define MISALIGN_TRAP_EN to report misaligned accesses via resp_err instead of aligning them.
module data_mem_access #(
  parameter int WORD_BITS = data_mem_access_pkg::WORD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_BITS-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [WORD_BITS-1:0] mem_wd,
  input  logic [WORD_BITS-1:0] mem_rd
);

  import data_mem_access_pkg::*;

  state_t               state;
  logic [31:0]          addr_q;
  logic [1:0]           size_q;
  logic                 sgn_q;
  logic                 we_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WORD_BITS-1:0] rd_q;
  logic [WORD_BITS-1:0] rdata_q;
  logic [1:0]           size_n;
  logic [31:0]          addr_n;
  logic [WORD_BITS-1:0] st_word;
  logic [WORD_BITS-1:0] ld_data;

  // Normalise size and force alignment so lane selection never sees stray low bits
  always_comb begin
    size_n = (req_size == 2'b11) ? SZ_WORD : req_size;
    addr_n = req_addr;
    if (size_n == SZ_HALF) addr_n[0] = 1'b0;
    if (size_n == SZ_WORD) addr_n[1:0] = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;
  assign misalign = ((size_n == SZ_HALF) && req_addr[0]) ||
                    ((size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  byte_lane_merge u_lane (
    .size     (size_q),
    .off      (addr_q[1:0]),
    .sgn      (sgn_q),
    .old_word (rd_q),
    .wdata    (wdata_q),
    .ld_word  (mem_rd),
    .st_word  (st_word),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= addr_n;
            size_q  <= size_n;
            sgn_q   <= req_signed;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
            if (misalign) begin
              state <= RESP;
              err_q <= 1'b1;
            end else
`endif
            if (!req_we || (size_n != SZ_WORD)) state <= READ;
            else                                 state <= WRITE;
          end
        end
        // Sub-word stores keep the fetched word for the merge in WRITE
        READ: begin
          rd_q <= mem_rd;
          if (we_q) begin
            state <= WRITE;
          end else begin
            rdata_q <= ld_data;
            state   <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign mem_we     = (state == WRITE);
  assign mem_addr   = ((state == READ) || (state == WRITE)) ? {2'b00, addr_q[31:2]} : 32'd0;
  assign mem_wd     = mem_we ? st_word : '0;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access against a 64-word memory model preloaded 10..0.
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [64];
  int          we_cnt = 0;
  logic [31:0] last_wd = '0;
  logic [31:0] last_wa = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  data_mem_access dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wd;
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wd;
      last_wa <= mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Present a request in IDLE and return #1 after the accept edge (cycle 1)
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
    req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                     input int lat, input logic [31:0] rdata, input logic err);
    int n;
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    issue(we, addr, size, sgn, wdata);
    n = 1;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_rdata"}, resp_rdata, rdata);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, err});
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 64; i++) mem[i] = (i <= 10) ? 32'(10 - i) : 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'b10;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    reset = 1'b0;

    // 1: word load at 0x8
    issue(1'b0, 32'h8, 2'b10, 1'b0, 32'h0);
    chk("t1_addr", mem_addr, 32'd2);
    chk("t1_busy", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t1_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1_rdata", resp_rdata, 32'd8);
    chk("t1_nowe", we_cnt, 0);
    @(posedge clk); #1;

    // 4: stalled response, then back-to-back accept
    resp_ready = 1'b0;
    issue(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", {31'd0, resp_valid}, 32'd1);
      chk("t4_rdata", resp_rdata, 32'd10);
      chk("t4_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    req_we = 1'b0; req_addr = 32'h8; req_size = 2'b10; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle_rdy", {31'd0, req_ready}, 32'd1);
    chk("t4_idle_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_next_addr", mem_addr, 32'd2);
    @(posedge clk); #1;
    chk("t4_next_rdata", resp_rdata, 32'd8);
    @(posedge clk); #1;

    // 5: reset during READ of a byte store
    w0 = we_cnt;
    issue(1'b1, 32'h0, 2'b00, 1'b0, 32'h55);
    chk("t5_inread_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_outs("t5");
    chk("t5_nowe", we_cnt, w0);
    chk("t5_mem0", mem[0], 32'd10);

    // 6: misaligned word load at 0x6
    w0 = we_cnt;
`ifdef MISALIGN_TRAP_EN
    txn("t6", 1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b1);
`else
    txn("t6", 1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 2, 32'd9, 1'b0);
`endif
    chk("t6_nowe", we_cnt, w0);

    // 2: byte store RMW and sub-word loads of the result
    w0 = we_cnt;
    txn("t2_st", 1'b1, 32'h5, 2'b00, 1'b0, 32'h000000AB, 3, 32'h0, 1'b0);
    chk("t2_we_once", we_cnt, w0 + 1);
    chk("t2_wd", last_wd, 32'h0000AB09);
    chk("t2_wa", last_wa, 32'd1);
    txn("t2_ldw", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 2, 32'h0000AB09, 1'b0);
    txn("t2_ldbs", 1'b0, 32'h5, 2'b00, 1'b1, 32'h0, 2, 32'hFFFFFFAB, 1'b0);
    txn("t2_ldbu", 1'b0, 32'h5, 2'b00, 1'b0, 32'h0, 2, 32'h000000AB, 1'b0);

    // 3: half store into upper lane, signed/unsigned half loads
    txn("t3_st", 1'b1, 32'h2, 2'b01, 1'b0, 32'h00008001, 3, 32'h0, 1'b0);
    chk("t3_wd", last_wd, 32'h8001000A);
    txn("t3_ldhs", 1'b0, 32'h2, 2'b01, 1'b1, 32'h0, 2, 32'hFFFF8001, 1'b0);
    txn("t3_ldhu", 1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 2, 32'h00008001, 1'b0);

    // word store (size 11 treated as word) and readback
    w0 = we_cnt;
    txn("t7_stw", 1'b1, 32'hC, 2'b11, 1'b0, 32'h12345678, 2, 32'h0, 1'b0);
    chk("t7_we_once", we_cnt, w0 + 1);
    chk("t7_wa", last_wa, 32'd3);
    txn("t7_ldw", 1'b0, 32'hC, 2'b10, 1'b1, 32'h0, 2, 32'h12345678, 1'b0);
    txn("t7_ldb3", 1'b0, 32'hF, 2'b00, 1'b1, 32'h0, 2, 32'h00000012, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_access.md
# data_mem_access

Initiator-side load/store unit driving the single-cycle word-addressed data memory. It accepts one CPU load or store request at a time over a valid/ready handshake. It converts byte addresses to word indices, performs byte/halfword stores as read-modify-write, and extracts/extends sub-word load data. It returns one response per request over a valid/ready handshake. It sits between the datapath's memory stage and the data memory's WE/A/WD/RD port.

## Interface
- `WORD_BITS`, default 32 – data word width; fixed at 32 for this design.
- `clk` input 1 – rising-edge clock.
- `reset` input 1 – synchronous, active-high reset.
- `req_valid` input 1 – request present.
- `req_ready` output 1 – unit can accept a request; high only in IDLE.
- `req_we` input 1 – 1 = store, 0 = load.
- `req_addr` input 32 – byte address.
- `req_size` input 2 – 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_signed` input 1 – sign-extend sub-word loads.
- `req_wdata` input 32 – store data, right-aligned.
- `resp_valid` output 1 – response held until accepted.
- `resp_ready` input 1 – response consumed.
- `resp_rdata` output 32 – load result, zero for stores.
- `resp_err` output 1 – misaligned access, only when MISALIGN_TRAP_EN is defined.
- `mem_we` output 1 – memory write enable.
- `mem_addr` output 32 – word index, equal to byte address >> 2.
- `mem_wd` output 32 – memory write data.
- `mem_rd` input 32 – combinational memory read data.

## Operation
- FSM states are IDLE, READ, WRITE, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, latch addr/size/signed/we/wdata.
  - Load or sub-word store → READ.
  - Word store → WRITE.
- **READ:**
  - Drive `mem_addr`; capture `mem_rd` at the edge.
  - Load → RESP.
  - Store → WRITE.
- **WRITE:**
  - `mem_we` = 1 for exactly one cycle.
  - `mem_wd` = store data merged into the captured word; for a word store it is the full `req_wdata`.
  - → RESP.
- **RESP:**
  - `resp_valid` = 1.
  - → IDLE when `resp_ready`.
- **Byte lanes (little-endian):**
  - Byte lane = `addr[1:0]`.
  - Halfword lane = `addr[1]`.
  - Merge replaces only the addressed lane; the other bytes are unchanged.
- **Load extraction:**
  - Shift the addressed lane to bit 0.
  - Zero-extend, or sign-extend when `req_signed`.
  - Word loads ignore `req_signed`.
- `mem_we`, `mem_addr` and `mem_wd` are decoded from the state and latched registers.
- `mem_addr` = 0 in IDLE and RESP.
- Reset outputs:
  - FSM in IDLE.
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wd` = 0.
- **Reset mid-operation:**
  - Abort and go to IDLE.
  - An RMW aborted in READ never writes.
  - Reset asserted in WRITE suppresses nothing already committed at that edge; `mem_we` is 0 from the next cycle.
- Requests arriving while not in IDLE are not accepted; the requester holds them.

## Timing
- Load: accept edge 0; READ in cycle 1; `resp_valid` from cycle 2. Latency 2.
- Word store: WRITE in cycle 1; response in cycle 2. Latency 2.
- Sub-word store: READ in cycle 1; WRITE in cycle 2; response in cycle 3. Latency 3.
- A back-to-back request is accepted in the cycle after the response handshake.
- Maximum throughput is one request per 3 cycles (load/word store) or per 4 cycles (sub-word store).
- `resp_rdata`/`resp_err` are stable while `resp_valid` && !`resp_ready`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A half access with `addr[0]`≠0, or a word access with `addr[1:0]`≠0, goes IDLE → RESP directly.
  - No memory access; `resp_err` = 1; `resp_rdata` = 0.
- Undefined:
  - Misaligned low bits are forced to alignment (half clears bit 0, word clears bits 1:0) before lane selection.
  - `resp_err` is tied to 0.

## Structure
- Package `data_mem_access_pkg` holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - The FSM state enum.
  - The `WORD_BITS` constant.
- Sub-module `byte_lane_merge` (combinational): store-merge path and load extract/extend path, selected by size/offset/signed.

## Test plan
Memory model is 64 words, preloaded mem[0..10] = 10 down to 0.
1. Load word addr 0x8 → `mem_addr` = 2 in cycle 1; `resp_rdata` = 8 in cycle 2; `mem_we` never asserted.
2. Store byte 0xAB at addr 0x5 (mem[1] = 9) → READ then one WRITE cycle with `mem_wd` = 0x0000AB09; mem[1] reads 0x0000AB09 afterwards.
3. Store half 0x8001 at addr 0x2, then signed half load at 0x2 → 0xFFFF8001; unsigned half load → 0x00008001.
4. Hold `resp_ready` = 0 for 5 cycles after a load of addr 0x0 → `resp_valid`/`resp_rdata` = 10 stable; `req_ready` = 0 throughout; next request is accepted the cycle after the handshake.
5. Assert `reset` during READ of a byte store to addr 0x0 → no `mem_we` pulse; mem[0] still 10; all outputs at reset values next cycle.
6. Word load at addr 0x6: with MISALIGN_TRAP_EN → `resp_err` = 1 at latency 1, no memory access; without it → `resp_rdata` = 9 (mem[1]), `resp_err` = 0.
